render_controller: RTL
======================

// Module: render_controller
// PURPOSE
//  Sits directly downstream of the instruction processor. Consumes executed
//  instructions (valid + render flag) and runs one frame per render instruction.
//  Scans every pixel (h,v), issues each as a request to the ray pipeline over a
//  valid/ready handshake, and bounds in-flight requests. Drives controller_busy
//  back to the processor, stalling it until every pixel result has returned.
// PARAMETERS
//  H_PIXELS         320  pixels per line; hcount range 0..H_PIXELS-1
//  V_PIXELS         180  lines per frame; vcount range 0..V_PIXELS-1
//  MAX_OUTSTANDING  8    maximum issued-but-not-completed pixel requests (>=1)
// PORTS
//  clk_100mhz        in   1   system clock, all logic on rising edge
//  rst_n             in   1   asynchronous reset, active-low
//  inst_valid        in   1   executed instruction valid (1-cycle pulse)
//  inst_is_render    in   1   instruction type is RENDER; qualified by inst_valid
//  mem_ready         in   1   scene memories (camera/light/geometry) loaded
//  controller_busy   out  1   high = processor must stall
//  pix_valid         out  1   pixel request valid
//  pix_ready         in   1   ray pipeline accepts request when pix_valid&pix_ready
//  pix_hcount        out  $clog2(H_PIXELS)  request pixel column
//  pix_vcount        out  $clog2(V_PIXELS)  request pixel row
//  pix_done          in   1   one pixel result returned this cycle
//  frame_done        out  1   1-cycle pulse when a frame fully completes
//  frame_count       out  16  frames completed since reset, wraps 0xFFFF->0
//  err_underflow     out  1   sticky: pix_done seen with zero outstanding
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; all outputs 0; counters 0; err cleared.
//   Reset mid-frame abandons the frame; late pix_done after reset counts as
//   underflow.
//  FSM: IDLE -> WAIT_MEM on inst_valid&inst_is_render (non-render insts ignored).
//   WAIT_MEM -> ISSUE when mem_ready=1 (same-cycle mem_ready still costs 1 cycle).
//   ISSUE -> DRAIN on handshake of last pixel (h=H_PIXELS-1, v=V_PIXELS-1).
//   DRAIN -> DONE when outstanding==0 (incl. same-cycle final pix_done)
//   DONE -> IDLE next cycle; frame_done=1 and frame_count+=1 in the DONE cycle.
//  controller_busy = (state!=IDLE) | (inst_valid & inst_is_render): high in the
//   accept cycle itself, low in the cycle after DONE. Render insts seen while
//   not IDLE are dropped.
//  Scan order: h increments first; h wraps H_PIXELS-1->0 with v+1; starts (0,0).
//   Counters advance only on handshake; hcount/vcount/valid hold while stalled.
//  pix_valid = (state==ISSUE) & (outstanding < MAX_OUTSTANDING), registered count.
//  outstanding: +1 on handshake, -1 on pix_done, both same cycle = no change;
//   width $clog2(MAX_OUTSTANDING+1). pix_done at outstanding==0: no decrement,
//   set err_underflow.
//  Latency: render inst accepted at cycle N, mem_ready high -> first pix_valid
//   at N+2.
// TESTING
//  1 H=4,V=2,MAX=8; render pulse, mem_ready=1, pix_ready=1, pix_done 3 cyc after
//    each issue -> 8 requests (0,0),(1,0)..(3,1) back-to-back; frame_done once;
//    frame_count=1; busy low after.
//  2 MAX=2, pix_done withheld -> exactly 2 handshakes then pix_valid=0; one
//    pix_done -> one more issue; outstanding never exceeds 2.
//  3 mem_ready=0 for 10 cycles after render -> busy=1, pix_valid=0 throughout;
//    first pix_valid 1 cycle after mem_ready rises.
//  4 pix_ready toggling 1010..., second render pulse and non-render pulse
//    mid-frame -> order and hold intact, both extra pulses ignored, frame_count=1.
//  5 Simultaneous handshake and pix_done at outstanding=1 -> stays 1; pix_done
//    in IDLE -> err_underflow=1 and stays set.
//  6 rst_n low during ISSUE at pixel (2,1) -> all outputs 0 immediately
//    (async); new render restarts at (0,0), frame_count=0 before completion.

Source files
------------

// File: rtl/render_controller.sv
// Frame render controller: scans every pixel of a frame into the ray pipeline
// over valid/ready, bounds in-flight requests and stalls the processor until done.
module render_controller #(
  parameter  int H_PIXELS        = 320,
  parameter  int V_PIXELS        = 180,
  parameter  int MAX_OUTSTANDING = 8,
  localparam int HW              = $clog2(H_PIXELS),
  localparam int VW              = $clog2(V_PIXELS),
  localparam int OW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk_100mhz,
  input  logic          rst_n,
  input  logic          inst_valid,
  input  logic          inst_is_render,
  input  logic          mem_ready,
  output logic          controller_busy,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [HW-1:0] pix_hcount,
  output logic [VW-1:0] pix_vcount,
  input  logic          pix_done,
  output logic          frame_done,
  output logic [15:0]   frame_count,
  output logic          err_underflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_MEM,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state, state_next;
  logic [OW-1:0] outstanding, outstanding_next;
  logic          render_req;
  logic          handshake;
  logic          last_pixel;
  logic          underflow;
  logic          retire;

  assign render_req = inst_valid & inst_is_render;
  assign handshake  = pix_valid & pix_ready;
  assign last_pixel = (pix_hcount == HW'(H_PIXELS - 1)) && (pix_vcount == VW'(V_PIXELS - 1));
  // A completion with nothing in flight is flagged, never allowed to wrap the count.
  assign underflow  = pix_done && (outstanding == '0);
  assign retire     = pix_done && !underflow;

  assign controller_busy = (state != S_IDLE) | render_req;
  assign pix_valid       = (state == S_ISSUE) && (outstanding < OW'(MAX_OUTSTANDING));
  assign frame_done      = (state == S_DONE);

  always_comb begin
    outstanding_next = outstanding;
    if (handshake && !retire)      outstanding_next = outstanding + OW'(1);
    else if (retire && !handshake) outstanding_next = outstanding - OW'(1);
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (render_req) state_next = S_WAIT_MEM;
      S_WAIT_MEM: if (mem_ready) state_next = S_ISSUE;
      S_ISSUE:    if (handshake && last_pixel) state_next = S_DRAIN;
      S_DRAIN:    if (outstanding_next == '0) state_next = S_DONE;
      S_DONE:     state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      outstanding   <= '0;
      pix_hcount    <= '0;
      pix_vcount    <= '0;
      frame_count   <= '0;
      err_underflow <= 1'b0;
    end else begin
      state       <= state_next;
      outstanding <= outstanding_next;
      if (underflow) err_underflow <= 1'b1;
      // Count lands with the DONE cycle so frame_done and the new count coincide.
      if (state == S_DRAIN && outstanding_next == '0) frame_count <= frame_count + 16'd1;
      if (state == S_IDLE && render_req) begin
        pix_hcount <= '0;
        pix_vcount <= '0;
      end else if (handshake) begin
        if (pix_hcount == HW'(H_PIXELS - 1)) begin
          pix_hcount <= '0;
          pix_vcount <= (pix_vcount == VW'(V_PIXELS - 1)) ? '0 : pix_vcount + VW'(1);
        end else begin
          pix_hcount <= pix_hcount + HW'(1);
        end
      end
    end
  end

endmodule
